// File: rtl/rs_station_pkg.sv
// Shared types for the arithmetic-path reservation station:
// opcode enum, ROB tag and data word types, entry layout.
package rs_station_pkg;

    localparam int ROB_POS_WIDTH = 4;
    localparam int OP_WIDTH      = 6;
    localparam int DATA_WIDTH    = 32;

    typedef logic [ROB_POS_WIDTH-1:0] rob_t;
    typedef logic [DATA_WIDTH-1:0]    word_t;

    localparam rob_t  ZERO_ROB  = '0;
    localparam word_t ZERO_WORD = '0;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_NOP = 6'd0,
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_SLL, OP_SRL, OP_SRA,
        OP_SLT, OP_SLTU,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
        OP_BLTU, OP_BGEU,
        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
    } op_e;

    typedef struct packed {
        word_t value;
        rob_t  tag;
    } operand_t;

    typedef struct packed {
        logic     busy;
        op_e      op;
        operand_t src1;
        operand_t src2;
        word_t    imm;
        word_t    pc;
        rob_t     rob_tag;
    } rs_entry_t;

    // Resolve a waiting operand against both result buses.
    // ALU wins if both match (both matching is illegal anyway).
    function automatic operand_t snoop(
        operand_t o,
        rob_t     alu_tag,
        word_t    alu_val,
        rob_t     lsb_tag,
        word_t    lsb_val
    );
        operand_t r;
        r = o;
        if (o.tag != ZERO_ROB && o.tag == alu_tag) begin
            r.value = alu_val;
            r.tag   = ZERO_ROB;
        end else if (o.tag != ZERO_ROB && o.tag == lsb_tag) begin
            r.value = lsb_val;
            r.tag   = ZERO_ROB;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_station_select.sv
// Lowest-index priority encoders: first free slot and
// first ready slot of the reservation station.
module rs_station_select #(
    parameter int N    = 16,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    busy_i,
    input  logic [N-1:0]    ready_i,
    output logic [IDXW-1:0] free_idx_o,
    output logic            free_vld_o,
    output logic [IDXW-1:0] rdy_idx_o,
    output logic            rdy_vld_o
);

    // Scan downwards so the lowest matching index wins.
    always_comb begin
        free_idx_o = '0;
        free_vld_o = 1'b0;
        rdy_idx_o  = '0;
        rdy_vld_o  = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy_i[i]) begin
                free_idx_o = IDXW'(i);
                free_vld_o = 1'b1;
            end
            if (ready_i[i]) begin
                rdy_idx_o = IDXW'(i);
                rdy_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// Reservation station: holds ALU/branch micro-ops until both
// operands resolve, issues one per cycle to the ALU.
module rs_station
    import rs_station_pkg::*;
#(
    parameter int RS_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     rollback,
    input  logic                     in_valid,
    input  logic [OP_WIDTH-1:0]      in_op,
    input  logic [DATA_WIDTH-1:0]    in_value1,
    input  logic [ROB_POS_WIDTH-1:0] in_tag1,
    input  logic [DATA_WIDTH-1:0]    in_value2,
    input  logic [ROB_POS_WIDTH-1:0] in_tag2,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic [DATA_WIDTH-1:0]    in_pc,
    input  logic [ROB_POS_WIDTH-1:0] in_rob_tag,
    output logic                     out_full,
    input  logic [ROB_POS_WIDTH-1:0] alu_rob_tag,
    input  logic [DATA_WIDTH-1:0]    alu_value,
    input  logic [ROB_POS_WIDTH-1:0] lsb_rob_tag,
    input  logic [DATA_WIDTH-1:0]    lsb_value,
    output logic [OP_WIDTH-1:0]      out_op,
    output logic [DATA_WIDTH-1:0]    out_value1,
    output logic [DATA_WIDTH-1:0]    out_value2,
    output logic [DATA_WIDTH-1:0]    out_imm,
    output logic [DATA_WIDTH-1:0]    out_pc,
    output logic [ROB_POS_WIDTH-1:0] out_rob_tag
);

    localparam int IDXW = $clog2(RS_SIZE);

    rs_entry_t ent_q [RS_SIZE];
    rs_entry_t ent_d [RS_SIZE];

    op_e   op_q,  op_d;
    word_t v1_q,  v1_d;
    word_t v2_q,  v2_d;
    word_t imm_q, imm_d;
    word_t pc_q,  pc_d;
    rob_t  rob_q, rob_d;

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] ready;
    logic [IDXW-1:0]    free_idx;
    logic               free_vld;
    logic [IDXW-1:0]    rdy_idx;
    logic               rdy_vld;

    // Flatten registered entry state into busy/ready masks.
    always_comb begin
        busy  = '0;
        ready = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy[i]  = ent_q[i].busy;
            ready[i] = ent_q[i].busy
                     && ent_q[i].src1.tag == ZERO_ROB
                     && ent_q[i].src2.tag == ZERO_ROB;
        end
    end

    rs_station_select #(
        .N (RS_SIZE)
    ) u_select (
        .busy_i     (busy),
        .ready_i    (ready),
        .free_idx_o (free_idx),
        .free_vld_o (free_vld),
        .rdy_idx_o  (rdy_idx),
        .rdy_vld_o  (rdy_vld)
    );

    // Conservative: a same-cycle issue does not free a slot yet.
    assign out_full = &busy;

    // Next state: rollback, else issue, wakeup and dispatch.
    always_comb begin
        ent_d = ent_q;
        op_d  = OP_NOP;
        rob_d = ZERO_ROB;
        v1_d  = v1_q;
        v2_d  = v2_q;
        imm_d = imm_q;
        pc_d  = pc_q;
        if (rollback) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i].busy = 1'b0;
            end
        end else begin
            if (rdy_vld) begin
                op_d  = ent_q[rdy_idx].op;
                v1_d  = ent_q[rdy_idx].src1.value;
                v2_d  = ent_q[rdy_idx].src2.value;
                imm_d = ent_q[rdy_idx].imm;
                pc_d  = ent_q[rdy_idx].pc;
                rob_d = ent_q[rdy_idx].rob_tag;
                ent_d[rdy_idx].busy = 1'b0;
            end
            for (int i = 0; i < RS_SIZE; i++) begin
                if (ent_q[i].busy) begin
                    ent_d[i].src1 = snoop(ent_q[i].src1,
                        alu_rob_tag, alu_value,
                        lsb_rob_tag, lsb_value);
                    ent_d[i].src2 = snoop(ent_q[i].src2,
                        alu_rob_tag, alu_value,
                        lsb_rob_tag, lsb_value);
                end
            end
            if (in_valid && !out_full && free_vld) begin
                ent_d[free_idx].busy    = 1'b1;
                ent_d[free_idx].op      = op_e'(in_op);
                ent_d[free_idx].src1    = snoop(
                    '{value: in_value1, tag: in_tag1},
                    alu_rob_tag, alu_value,
                    lsb_rob_tag, lsb_value);
                ent_d[free_idx].src2    = snoop(
                    '{value: in_value2, tag: in_tag2},
                    alu_rob_tag, alu_value,
                    lsb_rob_tag, lsb_value);
                ent_d[free_idx].imm     = in_imm;
                ent_d[free_idx].pc      = in_pc;
                ent_d[free_idx].rob_tag = in_rob_tag;
            end
        end
    end

    // State update; rdy=0 freezes entries and idles the ALU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
            op_q  <= OP_NOP;
            v1_q  <= ZERO_WORD;
            v2_q  <= ZERO_WORD;
            imm_q <= ZERO_WORD;
            pc_q  <= ZERO_WORD;
            rob_q <= ZERO_ROB;
        end else if (!rdy) begin
            op_q  <= OP_NOP;
            rob_q <= ZERO_ROB;
        end else begin
            ent_q <= ent_d;
            op_q  <= op_d;
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            imm_q <= imm_d;
            pc_q  <= pc_d;
            rob_q <= rob_d;
        end
    end

    assign out_op      = op_q;
    assign out_value1  = v1_q;
    assign out_value2  = v2_q;
    assign out_imm     = imm_q;
    assign out_pc      = pc_q;
    assign out_rob_tag = rob_q;

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed scenarios plus
// randomized traffic against a behavioural station model.
module tb_rs_station;
    import rs_station_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        in_valid;
    logic [5:0]  in_op;
    logic [31:0] in_value1;
    logic [3:0]  in_tag1;
    logic [31:0] in_value2;
    logic [3:0]  in_tag2;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic [3:0]  in_rob_tag;
    logic        out_full;
    logic [3:0]  alu_rob_tag;
    logic [31:0] alu_value;
    logic [3:0]  lsb_rob_tag;
    logic [31:0] lsb_value;
    logic [5:0]  out_op;
    logic [31:0] out_value1;
    logic [31:0] out_value2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [3:0]  out_rob_tag;

    int checks = 0;
    int errors = 0;

    rs_station #(.RS_SIZE(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .rollback    (rollback),
        .in_valid    (in_valid),
        .in_op       (in_op),
        .in_value1   (in_value1),
        .in_tag1     (in_tag1),
        .in_value2   (in_value2),
        .in_tag2     (in_tag2),
        .in_imm      (in_imm),
        .in_pc       (in_pc),
        .in_rob_tag  (in_rob_tag),
        .out_full    (out_full),
        .alu_rob_tag (alu_rob_tag),
        .alu_value   (alu_value),
        .lsb_rob_tag (lsb_rob_tag),
        .lsb_value   (lsb_value),
        .out_op      (out_op),
        .out_value1  (out_value1),
        .out_value2  (out_value2),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_rob_tag (out_rob_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a bag of 16 slots and the ALU latch.
    logic        m_busy [16];
    logic [5:0]  m_op   [16];
    logic [31:0] m_v1   [16];
    logic [3:0]  m_t1   [16];
    logic [31:0] m_v2   [16];
    logic [3:0]  m_t2   [16];
    logic [31:0] m_imm  [16];
    logic [31:0] m_pc   [16];
    logic [3:0]  m_rob  [16];
    logic [5:0]  e_op;
    logic [31:0] e_v1, e_v2, e_imm, e_pc;
    logic [3:0]  e_rob;

    function automatic logic m_full();
        int n = 0;
        for (int i = 0; i < 16; i++) n += m_busy[i] ? 1 : 0;
        return n == 16;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        e_op = 0; e_rob = 0;
        e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0;
    endtask

    // Value an operand ends up with given this cycle's buses.
    task automatic m_res(inout logic [3:0] t,
                         inout logic [31:0] v);
        if (t != 0 && t == alu_rob_tag) begin
            v = alu_value; t = 0;
        end else if (t != 0 && t == lsb_rob_tag) begin
            v = lsb_value; t = 0;
        end
    endtask

    task automatic model_edge();
        int r = -1;
        int f = -1;
        if (!rdy) begin
            e_op = 0; e_rob = 0;
            return;
        end
        if (rollback) begin
            for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
            e_op = 0; e_rob = 0;
            return;
        end
        for (int i = 15; i >= 0; i--) begin
            if (m_busy[i] && m_t1[i] == 0 && m_t2[i] == 0) r = i;
            if (!m_busy[i]) f = i;
        end
        if (r >= 0) begin
            e_op = m_op[r]; e_v1 = m_v1[r]; e_v2 = m_v2[r];
            e_imm = m_imm[r]; e_pc = m_pc[r]; e_rob = m_rob[r];
            m_busy[r] = 1'b0;
        end else begin
            e_op = 0; e_rob = 0;
        end
        for (int i = 0; i < 16; i++) begin
            if (m_busy[i]) begin
                m_res(m_t1[i], m_v1[i]);
                m_res(m_t2[i], m_v2[i]);
            end
        end
        if (in_valid && f >= 0) begin
            m_busy[f] = 1'b1;
            m_op[f] = in_op;
            m_v1[f] = in_value1; m_t1[f] = in_tag1;
            m_v2[f] = in_value2; m_t2[f] = in_tag2;
            m_res(m_t1[f], m_v1[f]);
            m_res(m_t2[f], m_v2[f]);
            m_imm[f] = in_imm; m_pc[f] = in_pc;
            m_rob[f] = in_rob_tag;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rdy = 1; rollback = 0; in_valid = 0;
        in_op = 0; in_value1 = 0; in_tag1 = 0;
        in_value2 = 0; in_tag2 = 0; in_imm = 0;
        in_pc = 0; in_rob_tag = 0;
        alu_rob_tag = 0; alu_value = 0;
        lsb_rob_tag = 0; lsb_value = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic disp(logic [5:0] op, logic [31:0] v1,
                        logic [3:0] t1, logic [31:0] v2,
                        logic [3:0] t2, logic [3:0] rob);
        in_valid = 1; in_op = op;
        in_value1 = v1; in_tag1 = t1;
        in_value2 = v2; in_tag2 = t2;
        in_rob_tag = rob;
        in_imm = 32'h100 + 32'(rob);
        in_pc = 32'h4000 + 32'(rob);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_op !== 0 || out_rob_tag !== 0 || out_full !== 0) begin
            errors++;
            $display("FAIL reset op=%0d tag=%0d full=%0d want 0/0/0",
                     out_op, out_rob_tag, out_full);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (out_op !== 0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d op=%0d want 0",
                         i, out_op);
            end
        end
    endtask

    task automatic test_add();
        do_reset();
        disp(OP_ADD, 5, 0, 7, 0, 3);
        cyc();
        idle();
        cyc();
        checks++;
        if (out_op !== OP_ADD || out_value1 !== 5
            || out_value2 !== 7 || out_rob_tag !== 3) begin
            errors++;
            $display("FAIL add op=%0d v1=%0d v2=%0d tag=%0d want %0d/5/7/3",
                     out_op, out_value1, out_value2, out_rob_tag,
                     OP_ADD);
        end
        cyc();
        checks++;
        if (out_op !== 0) begin
            errors++;
            $display("FAIL add_once op=%0d want 0", out_op);
        end
    endtask

    task automatic test_wakeup_alu();
        do_reset();
        disp(OP_SUB, 0, 4, 10, 0, 6);
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (out_op !== 0) begin
                errors++;
                $display("FAIL sub_wait cyc %0d op=%0d want 0",
                         i, out_op);
            end
        end
        alu_rob_tag = 4; alu_value = 20;
        cyc();
        idle();
        checks++;
        if (out_op !== 0) begin
            errors++;
            $display("FAIL sub_wake_edge op=%0d want 0", out_op);
        end
        cyc();
        checks++;
        if (out_op !== OP_SUB || out_value1 !== 20
            || out_value2 !== 10 || out_rob_tag !== 6) begin
            errors++;
            $display("FAIL sub_issue op=%0d v1=%0d v2=%0d tag=%0d want %0d/20/10/6",
                     out_op, out_value1, out_value2, out_rob_tag,
                     OP_SUB);
        end
    endtask

    task automatic test_dispatch_capture();
        do_reset();
        disp(OP_BEQ, 1, 0, 0, 5, 2);
        lsb_rob_tag = 5; lsb_value = 32'h99;
        cyc();
        idle();
        cyc();
        checks++;
        if (out_op !== OP_BEQ || out_value2 !== 32'h99
            || out_rob_tag !== 2) begin
            errors++;
            $display("FAIL capture op=%0d v2=%0h tag=%0d want %0d/99/2",
                     out_op, out_value2, out_rob_tag, OP_BEQ);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            disp(OP_ADD, 0, 7, i, 0, 4'(i));
            cyc();
        end
        checks++;
        if (out_full !== 1) begin
            errors++;
            $display("FAIL full_set full=%0d want 1", out_full);
        end
        disp(OP_ADD, 0, 0, 99, 0, 15);
        cyc();
        idle();
        checks++;
        if (out_full !== 1 || out_op !== 0) begin
            errors++;
            $display("FAIL full_ignore full=%0d op=%0d want 1/0",
                     out_full, out_op);
        end
        alu_rob_tag = 7; alu_value = 32'hAB;
        cyc();
        idle();
        for (int i = 0; i < 16; i++) begin
            cyc();
            checks++;
            if (out_op !== OP_ADD || out_value2 !== 32'(i)
                || out_value1 !== 32'hAB) begin
                errors++;
                $display("FAIL full_order %0d op=%0d v1=%0h v2=%0d want %0d/ab/%0d",
                         i, out_op, out_value1, out_value2,
                         OP_ADD, i);
            end
            if (i == 0) begin
                checks++;
                if (out_full !== 0) begin
                    errors++;
                    $display("FAIL full_drop full=%0d want 0",
                             out_full);
                end
            end
        end
        cyc();
        checks++;
        if (out_op !== 0) begin
            errors++;
            $display("FAIL full_drain op=%0d want 0", out_op);
        end
    endtask

    task automatic test_rollback();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp(OP_OR, 0, 9, 0, 0, 4'(i + 1));
            cyc();
        end
        idle();
        rollback = 1;
        cyc();
        idle();
        checks++;
        if (out_full !== 0 || out_op !== 0) begin
            errors++;
            $display("FAIL rollback full=%0d op=%0d want 0/0",
                     out_full, out_op);
        end
        alu_rob_tag = 9; alu_value = 1;
        cyc();
        idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (out_op !== 0) begin
                errors++;
                $display("FAIL rollback_noissue %0d op=%0d want 0",
                         i, out_op);
            end
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        disp(OP_XOR, 3, 0, 4, 0, 1);
        cyc();
        idle();
        rdy = 0;
        disp(OP_AND, 8, 0, 9, 0, 2);
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (out_op !== 0 || out_rob_tag !== 0) begin
                errors++;
                $display("FAIL rdy_freeze %0d op=%0d tag=%0d want 0/0",
                         i, out_op, out_rob_tag);
            end
        end
        idle();
        cyc();
        checks++;
        if (out_op !== OP_XOR || out_rob_tag !== 1
            || out_value1 !== 3) begin
            errors++;
            $display("FAIL rdy_resume op=%0d tag=%0d v1=%0d want %0d/1/3",
                     out_op, out_rob_tag, out_value1, OP_XOR);
        end
        cyc();
        checks++;
        if (out_op !== 0) begin
            errors++;
            $display("FAIL rdy_nodisp op=%0d want 0", out_op);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp(OP_ADD, 32'(i + 1), 0, 1, 0, 4'(i + 1));
            cyc();
        end
        disp(OP_ADD, 9, 0, 9, 0, 9);
        cyc();
        idle();
        rst = 0;
        model_reset();
        #1;
        checks++;
        if (out_op !== 0 || out_rob_tag !== 0
            || out_value1 !== 0 || out_full !== 0) begin
            errors++;
            $display("FAIL async_rst op=%0d tag=%0d v1=%0d full=%0d want 0",
                     out_op, out_rob_tag, out_value1, out_full);
        end
        @(posedge clk);
        #1 rst = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (out_op !== 0) begin
                errors++;
                $display("FAIL async_rst_discard %0d op=%0d want 0",
                         i, out_op);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 39) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_op = 6'($urandom_range(1, 20));
            in_value1 = $urandom;
            in_value2 = $urandom;
            in_tag1 = ($urandom_range(0, 1) == 0) ? 4'd0
                      : 4'($urandom_range(1, 6));
            in_tag2 = ($urandom_range(0, 1) == 0) ? 4'd0
                      : 4'($urandom_range(1, 6));
            in_imm = $urandom;
            in_pc = $urandom;
            in_rob_tag = 4'($urandom);
            alu_rob_tag = 4'($urandom_range(0, 6));
            alu_value = $urandom;
            lsb_rob_tag = 4'($urandom_range(0, 6));
            if (lsb_rob_tag == alu_rob_tag) lsb_rob_tag = 0;
            lsb_value = $urandom;
            cyc();
            checks++;
            if (out_op !== e_op || out_rob_tag !== e_rob
                || out_full !== m_full()) begin
                errors++;
                $display("FAIL rnd_ctl cyc %0d op=%0d tag=%0d full=%0d want %0d/%0d/%0d",
                         n, out_op, out_rob_tag, out_full,
                         e_op, e_rob, m_full());
            end
            checks++;
            if (out_value1 !== e_v1 || out_value2 !== e_v2
                || out_imm !== e_imm || out_pc !== e_pc) begin
                errors++;
                $display("FAIL rnd_data cyc %0d v1=%h v2=%h imm=%h pc=%h want %h/%h/%h/%h",
                         n, out_value1, out_value2, out_imm, out_pc,
                         e_v1, e_v2, e_imm, e_pc);
            end
        end
    endtask

    initial begin
        rst = 0;
        idle();
        test_reset();
        test_add();
        test_wakeup_alu();
        test_dispatch_capture();
        test_full();
        test_rollback();
        test_rdy_freeze();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
